// File: rtl/vga_banner_ctrl.sv
// rtl/vga_banner_ctrl.sv - frame-synchronous scroll/colour controller for the letter banner
//
// Purpose: accepts host commands over a valid/ready handshake, holds one
// pending command, and applies it together with the scroll motion only on
// the frame-end pixel so the banner never tears mid-frame.
//
// Ports:
//   vga_clk    in   pixel clock
//   sys_rst    in   asynchronous active-high reset
//   pix_x      in   current pixel column
//   pix_y      in   current pixel row
//   cmd_valid  in   host command valid
//   cmd_op     in   0=START 1=PAUSE 2=STOP 3=NEXT_COLOR
//   cmd_ready  out  controller can accept a command
//   start_x    out  banner left edge
//   fg_color   out  RGB565 letter colour
//   state      out  0=IDLE 1=SCROLL 2=PAUSE
//   frame_tick out  one-cycle pulse the cycle after frame end

module vga_banner_ctrl #(
  parameter int H_VALID      = 640,
  parameter int V_VALID      = 480,
  parameter int BANNER_W     = 250,
  parameter int START_X_INIT = 155,
  parameter int STEP         = 2,
  parameter int FRAME_DIV    = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic [9:0]  start_x,
  output logic [15:0] fg_color,
  output logic [1:0]  state,
  output logic        frame_tick
);

  localparam int MAX_X = H_VALID - BANNER_W;
  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_PAUSE = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_COLOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [9:0]         pos_q, pos_n;
  logic               dir_left_q, dir_left_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [1:0]         color_q, color_n;
  logic               pend_valid_q, pend_valid_n;
  logic [1:0]         pend_op_q, pend_op_n;
  logic               started;
  logic               frame_end;
  logic [10:0]        sum_right;

  // Blanking coordinates (e.g. 10'h3FF) can never equal the last active pixel.
  assign frame_end = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
  assign sum_right = {1'b0, pos_q} + 11'(STEP);

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      pos_q        <= 10'(START_X_INIT);
      dir_left_q   <= 1'b0;
      cnt_q        <= '0;
      color_q      <= 2'd0;
      pend_valid_q <= 1'b0;
      pend_op_q    <= 2'd0;
      frame_tick   <= 1'b0;
    end else begin
      state_q      <= state_n;
      pos_q        <= pos_n;
      dir_left_q   <= dir_left_n;
      cnt_q        <= cnt_n;
      color_q      <= color_n;
      pend_valid_q <= pend_valid_n;
      pend_op_q    <= pend_op_n;
      frame_tick   <= frame_end;
    end
  end

  always_comb begin
    state_n      = state_q;
    pos_n        = pos_q;
    dir_left_n   = dir_left_q;
    cnt_n        = cnt_q;
    color_n      = color_q;
    pend_valid_n = pend_valid_q;
    pend_op_n    = pend_op_q;
    started      = 1'b0;

    // Acceptance only happens while nothing is pending, so a command taken on
    // the frame-end cycle is not yet visible to the apply logic below and
    // naturally waits for the following frame end.
    if (cmd_valid && cmd_ready) begin
      pend_valid_n = 1'b1;
      pend_op_n    = cmd_op;
    end

    if (frame_end) begin
      if (pend_valid_q) begin
        pend_valid_n = 1'b0;
        case (pend_op_q)
          OP_START: begin
            state_n = ST_SCROLL;
            cnt_n   = '0;
            started = 1'b1;
          end
          OP_PAUSE: begin
            if (state_q == ST_SCROLL) state_n = ST_PAUSE;
          end
          OP_STOP: begin
            state_n    = ST_IDLE;
            pos_n      = 10'(START_X_INIT);
            dir_left_n = 1'b0;
            cnt_n      = '0;
          end
          default: begin
            color_n = color_q + 2'd1;
          end
        endcase
      end

      // Motion runs in the state that results from the command above.
      if (state_n == ST_SCROLL && !started) begin
        if (cnt_q == CNT_W'(FRAME_DIV - 1)) begin
          cnt_n = '0;
          if (!dir_left_q) begin
            if (sum_right >= 11'(MAX_X)) begin
              pos_n      = 10'(MAX_X);
              dir_left_n = 1'b1;
            end else begin
              pos_n = sum_right[9:0];
            end
          end else begin
            if (pos_q <= 10'(STEP)) begin
              pos_n      = 10'd0;
              dir_left_n = 1'b0;
            end else begin
              pos_n = pos_q - 10'(STEP);
            end
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    case (color_q)
      2'd0:    fg_color = 16'hFFFF;
      2'd1:    fg_color = 16'hF800;
      2'd2:    fg_color = 16'h07E0;
      default: fg_color = 16'h001F;
    endcase
  end

  assign cmd_ready = !pend_valid_q;
  assign start_x   = pos_q;
  assign state     = state_q;

endmodule

// File: tb/tb_vga_banner_ctrl.sv
// tb/tb_vga_banner_ctrl.sv - directed self-checking bench for vga_banner_ctrl

module tb_vga_banner_ctrl;

  logic        vga_clk;
  logic        sys_rst;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic [9:0]  start_x;
  logic [15:0] fg_color;
  logic [1:0]  state;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  vga_banner_ctrl dut (
    .vga_clk    (vga_clk),
    .sys_rst    (sys_rst),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .start_x    (start_x),
    .fg_color   (fg_color),
    .state      (state),
    .frame_tick (frame_tick)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Two blanking cycles followed by the last active pixel.
  task automatic end_frame();
    tick();
    tick();
    pix_x = 10'd639;
    pix_y = 10'd479;
    tick();
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) end_frame();
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    sys_rst   = 1'b1;
    pix_x     = 10'h3FF;
    pix_y     = 10'h3FF;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();

    // 1: reset state and idle frames
    check("rst_start_x", 32'(start_x), 32'd155);
    check("rst_fg", 32'(fg_color), 32'hFFFF);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_tick", 32'(frame_tick), 32'd0);
    for (int i = 0; i < 3; i++) begin
      end_frame();
      check("idle_tick_hi", 32'(frame_tick), 32'd1);
      tick();
      check("idle_tick_lo", 32'(frame_tick), 32'd0);
    end
    check("idle_start_x", 32'(start_x), 32'd155);

    // 2: START mid-frame
    tick();
    send_cmd(2'd0);
    check("start_ready_lo", 32'(cmd_ready), 32'd0);
    tick();
    check("start_ready_still_lo", 32'(cmd_ready), 32'd0);
    check("start_state_before", 32'(state), 32'd0);
    end_frame();
    check("start_state_f1", 32'(state), 32'd1);
    check("start_ready_back", 32'(cmd_ready), 32'd1);
    check("start_x_f1", 32'(start_x), 32'd155);
    end_frame();
    check("start_x_f2", 32'(start_x), 32'd155);
    end_frame();
    check("start_x_f3", 32'(start_x), 32'd157);
    frames(2);
    check("start_x_f5", 32'(start_x), 32'd159);

    // 3: right bound, bounce, left bound
    frames(230);
    check("scroll_389", 32'(start_x), 32'd389);
    frames(2);
    check("scroll_390_clamp", 32'(start_x), 32'd390);
    frames(2);
    check("scroll_388_left", 32'(start_x), 32'd388);
    frames(386);
    check("scroll_2", 32'(start_x), 32'd2);
    frames(2);
    check("scroll_0_clamp", 32'(start_x), 32'd0);
    frames(2);
    check("scroll_2_right", 32'(start_x), 32'd2);

    // 4: second command ignored while pending
    send_cmd(2'd2);
    end_frame();
    check("stop_state", 32'(state), 32'd0);
    check("stop_start_x", 32'(start_x), 32'd155);
    send_cmd(2'd0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    tick();
    tick();
    check("held_not_ready", 32'(cmd_ready), 32'd0);
    end_frame();
    check("held_state_scroll", 32'(state), 32'd1);
    check("held_ready_back", 32'(cmd_ready), 32'd1);
    tick();
    check("pause_accepted", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    end_frame();
    check("pause_state", 32'(state), 32'd2);
    check("pause_start_x", 32'(start_x), 32'd155);
    frames(3);
    check("pause_hold_x", 32'(start_x), 32'd155);

    // 5: colour cycling in IDLE
    send_cmd(2'd2);
    end_frame();
    check("stop2_state", 32'(state), 32'd0);
    send_cmd(2'd3);
    end_frame();
    check("color_1", 32'(fg_color), 32'hF800);
    send_cmd(2'd3);
    end_frame();
    check("color_2", 32'(fg_color), 32'h07E0);
    send_cmd(2'd3);
    end_frame();
    check("color_3", 32'(fg_color), 32'h001F);
    send_cmd(2'd3);
    end_frame();
    check("color_wrap", 32'(fg_color), 32'hFFFF);
    check("color_idle_x", 32'(start_x), 32'd155);
    check("color_idle_state", 32'(state), 32'd0);

    // 6: command accepted on the frame-end cycle, then async reset
    pix_x     = 10'd639;
    pix_y     = 10'd479;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    tick();
    cmd_valid = 1'b0;
    pix_x     = 10'h3FF;
    pix_y     = 10'h3FF;
    check("fe_accept_ready", 32'(cmd_ready), 32'd0);
    check("fe_accept_state", 32'(state), 32'd0);
    end_frame();
    check("fe_applied_state", 32'(state), 32'd1);
    send_cmd(2'd3);
    frames(2);
    check("fe_scroll_x", 32'(start_x), 32'd157);
    check("fe_color", 32'(fg_color), 32'hF800);
    end_frame();
    #2;
    sys_rst = 1'b1;
    #1;
    check("arst_start_x", 32'(start_x), 32'd155);
    check("arst_fg", 32'(fg_color), 32'hFFFF);
    check("arst_state", 32'(state), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    check("arst_tick", 32'(frame_tick), 32'd0);
    tick();
    sys_rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
